// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// stage-register bubble muxes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    // addi x0, x0, 0 -- what a flushed stage register is loaded with
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_perf_ctr.sv
// Stall and flush event counters for performance analysis; wrap modulo 2^CNT_W.
module hazard_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage enable/flush sequencing for the five-stage pipeline: load-use,
// multi-cycle MDU ops, data-memory wait states and EX-resolved redirects.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_is_mdu,
    input  logic             mdu_done,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mdu_go,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t state_q, state_next;
    logic        done_seen_q, done_next;
    logic        mem_stall, load_use, redirect_applied;

    assign mem_stall = mem_req & ~dmem_ready;
    assign load_use  = id_ex_mem_read & (id_ex_rd != '0) &
                       ((id_uses_rs1 & (id_rs1 == id_ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == id_ex_rd)));

    always_comb begin
        pc_en            = 1'b1;
        if_id_en         = 1'b1;
        id_ex_en         = 1'b1;
        ex_mem_en        = 1'b1;
        mem_wb_en        = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_flush     = 1'b0;
        mdu_go           = 1'b0;
        redirect_applied = 1'b0;
        state_next       = state_q;
        done_next        = done_seen_q;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = RUN;
            done_next    = 1'b0;
        end else if (mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            // An MDU op keeps ownership of EX through a freeze; leaving
            // MDU_WAIT here would re-issue mdu_go for the same instruction.
            if (state_q == MDU_WAIT) begin
                state_next = MDU_WAIT;
                if (mdu_done) done_next = 1'b1;
            end else begin
                state_next = MEM_WAIT;
            end
        end else if (state_q == MDU_WAIT) begin
            if (done_seen_q | mdu_done) begin
                state_next = RUN;
                done_next  = 1'b0;
            end else begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end
        end else begin
            // RUN, and the first unfrozen cycle out of MEM_WAIT
            state_next = RUN;
            if (ex_is_mdu) begin
                mdu_go       = 1'b1;
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                state_next   = MDU_WAIT;
                done_next    = 1'b0;
            end else if (ex_redirect) begin
                if_id_flush      = 1'b1;
                id_ex_flush      = 1'b1;
                redirect_applied = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            done_seen_q <= done_next;
        end
    end

    assign state_o = state_q;

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (~pc_en),
        .flush_inc (redirect_applied),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic        ex_is_mdu, mdu_done, ex_redirect, mem_req, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mdu_go;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt, flush_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_is_mdu      (ex_is_mdu),
        .mdu_done       (mdu_done),
        .ex_redirect    (ex_redirect),
        .mem_req        (mem_req),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .mdu_go         (mdu_go),
        .state_o        (state_o),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // enables {pc,if_id,id_ex,ex_mem,mem_wb}, flushes {if_id,id_ex,ex_mem}
    task automatic checkCtrl(input string tag, input logic [4:0] en, input logic [2:0] fl, input logic go);
        checkOutput({tag, ".en"}, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, en});
        checkOutput({tag, ".flush"}, {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, {29'd0, fl});
        checkOutput({tag, ".go"}, {31'd0, mdu_go}, {31'd0, go});
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic mdu, input logic done, input logic redir,
                                 input logic mreq, input logic rdy);
        rst = r; id_ex_mem_read = ld; id_ex_rd = rd;
        id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_is_mdu = mdu; mdu_done = done; ex_redirect = redir;
        mem_req = mreq; dmem_ready = rdy;
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset values
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkCtrl("reset", 5'b00000, 3'b111, 0);
        stepCycle();
        stepCycle();
        idle();
        checkOutput("post_rst.state", {30'd0, state_o}, 32'd0);
        checkOutput("post_rst.stall_cnt", stall_cnt, 32'd0);
        checkOutput("post_rst.flush_cnt", flush_cnt, 32'd0);
        checkCtrl("post_rst", 5'b11111, 3'b000, 0);
        stepCycle();

        // load to x5 in EX, ID reads x5 via rs2
        applyStimulus(0, 1, 5'd5, 5'd3, 1, 5'd5, 1, 0, 0, 0, 0, 1);
        checkCtrl("load_use", 5'b00111, 3'b010, 0);
        stepCycle();
        idle();
        checkOutput("load_use.stall_cnt", stall_cnt, 32'd1);
        checkCtrl("after_load_use", 5'b11111, 3'b000, 0);
        stepCycle();

        // load with rd = x0, then load whose match is on an unused source
        applyStimulus(0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 1);
        checkCtrl("load_x0", 5'b11111, 3'b000, 0);
        stepCycle();
        applyStimulus(0, 1, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0, 0, 0, 1);
        checkCtrl("load_unused_rs2", 5'b11111, 3'b000, 0);
        stepCycle();
        idle();
        checkOutput("no_stall.stall_cnt", stall_cnt, 32'd1);

        // MDU op with 3 busy cycles: done pulses in the 4th cycle after go
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        checkCtrl("mdu_go", 5'b00011, 3'b001, 1);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("mdu_wait.state", {30'd0, state_o}, 32'd1);
            checkCtrl("mdu_wait", 5'b00011, 3'b001, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        checkCtrl("mdu_exit", 5'b11111, 3'b000, 0);
        stepCycle();
        idle();
        checkOutput("mdu_done.state", {30'd0, state_o}, 32'd0);
        checkOutput("mdu.stall_cnt", stall_cnt, 32'd5);
        stepCycle();

        // mem_stall for 2 cycles inside MDU_WAIT with done in the first
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        checkCtrl("mdu2_go", 5'b00011, 3'b001, 1);
        stepCycle();
        checkCtrl("mdu2_wait", 5'b00011, 3'b001, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        checkCtrl("mdu_memstall1", 5'b00000, 3'b000, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("mdu_memstall2.state", {30'd0, state_o}, 32'd1);
        checkCtrl("mdu_memstall2", 5'b00000, 3'b000, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        checkOutput("mdu_latched.state", {30'd0, state_o}, 32'd1);
        checkCtrl("mdu_latched_exit", 5'b11111, 3'b000, 0);
        stepCycle();
        idle();
        checkOutput("mdu2_done.state", {30'd0, state_o}, 32'd0);
        checkOutput("mdu2.stall_cnt", stall_cnt, 32'd9);

        // redirect together with load_use
        applyStimulus(0, 1, 5'd5, 5'd5, 1, 5'd5, 1, 0, 0, 1, 0, 1);
        checkCtrl("redir_load_use", 5'b11111, 3'b110, 0);
        stepCycle();
        idle();
        checkOutput("redir.flush_cnt", flush_cnt, 32'd1);
        checkOutput("redir.stall_cnt", stall_cnt, 32'd9);

        // redirect frozen by a memory wait, applied once afterwards
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkCtrl("redir_frozen", 5'b00000, 3'b000, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("mem_wait.state", {30'd0, state_o}, 32'd2);
        checkCtrl("redir_released", 5'b11111, 3'b110, 0);
        stepCycle();
        idle();
        checkOutput("released.state", {30'd0, state_o}, 32'd0);
        checkOutput("released.flush_cnt", flush_cnt, 32'd2);
        checkOutput("released.stall_cnt", stall_cnt, 32'd10);

        // reset in MDU_WAIT, then a fresh mdu_go
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        stepCycle();
        checkOutput("pre_rst.state", {30'd0, state_o}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        checkCtrl("rst_in_mdu", 5'b00000, 3'b111, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        checkOutput("rst_mdu.state", {30'd0, state_o}, 32'd0);
        checkOutput("rst_mdu.stall_cnt", stall_cnt, 32'd0);
        checkOutput("rst_mdu.flush_cnt", flush_cnt, 32'd0);
        checkCtrl("rst_mdu_rego", 5'b00011, 3'b001, 1);
        stepCycle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequencing controller for the five-stage RISC-V pipeline. It issues per-stage enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, covering four cases:
- load-use stalls that forwarding cannot cover;
- multi-cycle MDU (mul/div) operations in EX;
- data-memory wait states;
- branch/jump redirects resolved in EX.

It sits beside the forwarding unit and keeps stall/flush event counters for performance analysis.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- id_ex_rd  in  REG_W  destination of the instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- ex_is_mdu  in  1  EX instruction is mul/div
- mdu_done  in  1  MDU result valid (1-cycle pulse)
- ex_redirect  in  1  taken branch/jump resolved in EX
- mem_req  in  1  MEM-stage load/store active
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a NOP bubble into that register (acts only when its enable is 1)
- mdu_go  out  1  start pulse to MDU
- state_o  out  2  current FSM state
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
FSM states: RUN, MDU_WAIT, MEM_WAIT.

Derived conditions:
- mem_stall = mem_req & ~dmem_ready.
- load_use = id_ex_mem_read & (id_ex_rd != 0) & ((id_uses_rs1 & id_rs1 == id_ex_rd) | (id_uses_rs2 & id_rs2 == id_ex_rd)).

Priority, highest first:

1. **mem_stall, in any state.**
   - All five enables 0; all flushes 0.
   - Next state MEM_WAIT, unless the FSM is already in MDU_WAIT with the MDU running; then it stays in MDU_WAIT, and mem_stall still freezes everything.
2. **MDU handling.**
   - RUN with ex_is_mdu:
     - mdu_go = 1 for exactly that cycle.
     - pc_en, if_id_en, id_ex_en = 0.
     - ex_mem_en = 1, ex_mem_flush = 1.
     - Next state MDU_WAIT.
   - MDU_WAIT: same holds and bubble, with mdu_go = 0.
   - Exit when done_seen is set. done_seen = mdu_done registered, or mdu_done arriving this cycle.
   - In the exit cycle: all enables 1, no flush, next state RUN, done_seen cleared.
   - mdu_done arriving during a mem_stall cycle is latched into done_seen, never lost.
3. **ex_redirect, in RUN.**
   - All enables 1; if_id_flush = 1, id_ex_flush = 1.
   - Redirect wins over a simultaneous load_use.
4. **load_use, in RUN.**
   - pc_en = 0, if_id_en = 0.
   - id_ex_en = 1, id_ex_flush = 1.
   - The EX/MEM and MEM/WB stages advance.
5. **Otherwise:** all enables 1, flushes 0.

Other rules:
- MEM_WAIT → RUN on the first cycle with ~mem_stall. That cycle is evaluated with RUN rules, so a frozen redirect or load-use applies then.
- A redirect held during a freeze stays asserted, because EX is frozen, and is applied once.

Counters:
- stall_cnt increments on any cycle with pc_en = 0.
- flush_cnt increments on each redirect cycle that is applied.
- Both wrap modulo 2^CNT_W.

## Timing
- All outputs except counters and state_o are combinational from inputs and state; state, done_seen and counters are registered on the clk rising edge.
- Latencies:
  - load-use inserts exactly 1 bubble;
  - redirect costs 2 bubbles;
  - an MDU op of N busy cycles holds the front end N+1 cycles (go cycle plus wait).
- Values while rst = 1:
  - all enables 0;
  - if_id_flush, id_ex_flush, ex_mem_flush = 1;
  - mdu_go = 0.
- Values on the first cycle after rst:
  - state RUN;
  - done_seen 0;
  - counters 0.
- Reset mid-MDU or mid-MEM_WAIT returns to RUN with no mdu_go issued. The MDU shares rst.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum typedef (RUN = 2'd0, MDU_WAIT = 2'd1, MEM_WAIT = 2'd2);
  - NOP encoding constant 32'h0000_0013, shared with the bubble muxes.
- One sub-module, hazard_perf_ctr: two CNT_W counters with increment inputs and sync reset.

## Test plan
- Load to x5 in EX, ID reads x5 via rs2 (id_uses_rs2 = 1) → one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cnt = 1.
- Same load, but rd = x0, or ID does not use the matching register → no stall.
- ex_is_mdu with mdu_done 3 cycles later → mdu_go high for 1 cycle only; front end held 4 cycles; ex_mem_flush high for 4 cycles; RUN on cycle 5.
- mem_stall for 2 cycles while in MDU_WAIT, with mdu_done pulsing in the first of them → all enables 0 for both cycles; exit to RUN on the next cycle with ~mem_stall.
- ex_redirect together with load_use → if_id_flush = 1, id_ex_flush = 1, pc_en = 1; flush_cnt increments by 1, stall_cnt does not.
- rst asserted in MDU_WAIT → next cycle state_o = 0, counters 0; a later ex_is_mdu restarts with a fresh mdu_go.
